sseg4_scan: RTL and testbench
=============================

SSEG4_SCAN -- requirements
Module: sseg4_scan

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 100000, clock cycles each digit is lit; legal range 2..2**24.
REQ-002 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port i_valid  input  1  new display frame offered.
REQ-005 SHALL have port o_ready  output  1  pending slot empty, can accept a frame.
REQ-006 SHALL have port i_hex  input  16  four nibbles; digit k uses bits [4k+3:4k].
REQ-007 SHALL have port i_dp  input  4  decimal point per digit, active-high.
REQ-008 SHALL have port i_en  input  4  digit enable mask; 0 means the digit is dark.
REQ-009 SHALL have port o_hex  output  4  nibble of the current digit, to the hextosseg decode stage.
REQ-010 SHALL have port o_dp  output  1  decimal point of the current digit, to the hextosseg decode stage.
REQ-011 SHALL have port o_an_n  output  4  digit anodes, active-low, at most one low.
REQ-012 SHALL have port o_frame_tick  output  1  one-cycle pulse when the digit index wraps 3->0.

Function
REQ-013 SHALL run a prescaler counting 0..DWELL_CYCLES-1 and wrapping to 0; dwell_tick is asserted in the wrap cycle.
REQ-014 SHALL advance the 2-bit digit index on dwell_tick: 0->1->2->3->0.
REQ-015 SHALL pulse o_frame_tick in the cycle the index goes 3->0; one full frame therefore spans 4*DWELL_CYCLES cycles.
REQ-016 SHALL drive o_ready = NOT pending_full.
REQ-017 SHALL capture {i_hex, i_dp, i_en} into the pending register and set pending_full when i_valid and o_ready are both 1.
REQ-018 SHALL ignore i_valid while o_ready=0; no overwrite and no error.
REQ-019 SHALL, on the 3->0 wrap edge with pending_full=1, copy pending to the active register and clear pending_full; o_ready returns to 1 in the next cycle.
REQ-020 SHALL, when a capture and a 3->0 wrap coincide with pending_full=0, store the frame in pending only; it is promoted at the following wrap. The active register never changes mid-frame.
REQ-021 SHALL decode o_hex, o_dp and o_an_n combinationally from the registered index and active register; there is no added latency from an index change.
REQ-022 SHALL drive o_an_n[idx]=0 and the other bits 1 when active en[idx]=1.
REQ-023 SHALL drive o_an_n=4'b1111 when active en[idx]=0; o_hex and o_dp still carry that digit's data.
REQ-024 SHALL never hold two o_an_n bits low at once, including across index transitions.

Reset
REQ-025 SHALL asynchronously clear, on i_rst=1: prescaler=0, index=0, active register=0, pending register=0, pending_full=0.
REQ-026 SHALL produce these outputs during and after reset: o_an_n=4'b1111, o_hex=0, o_dp=0, o_frame_tick=0, o_ready=1.
REQ-027 SHALL, on reset mid-frame, discard any pending frame and restart the scan at digit 0 with a full dwell.

Configuration
REQ-028 SHALL implement leading-zero blanking when macro SSEG4_SCAN_LZB_EN is defined: digit k (k=3..1) is treated as disabled when its nibble and every higher nibble are 0; digit 0 is never blanked.
REQ-029 SHALL, with SSEG4_SCAN_LZB_EN undefined, light digits from i_en alone, with identical ports and timing.

Structure
REQ-030 SHALL take from a shared package sseg4_pkg: a frame typedef {hex[15:0], dp[3:0], en[3:0]}, a digit-index typedef (2 bits), and constant SSEG_DIGITS=4.
REQ-031 SHALL implement the prescaler as sub-module sseg4_tick_gen, parameterised by DWELL_CYCLES, outputting dwell_tick.

Verification (DWELL_CYCLES=4)
REQ-032 SHALL cover reset release: o_an_n=1111, o_ready=1; after the first load is promoted, anodes cycle 1110,1101,1011,0111 every 4 cycles and o_frame_tick pulses every 16 cycles.
REQ-033 SHALL cover a load of hex=16'h1234, dp=4'b0101, en=4'hF: after the next wrap, digit 0 shows o_hex=4, o_dp=1; digit 1 shows 3, 0; digit 2 shows 2, 1; digit 3 shows 1, 0.
REQ-034 SHALL cover back-to-back i_valid with 16'hAAAA then 16'hBBBB: only AAAA is accepted, o_ready=0 until the wrap, and BBBB is accepted after o_ready rises.
REQ-035 SHALL cover a load issued in the wrap cycle: the old frame is displayed for one further full frame, then the new one.
REQ-036 SHALL cover en=4'b1010: digits 0 and 2 dwell with o_an_n=1111 while o_hex still follows the index.
REQ-037 SHALL cover the macro set with hex=16'h0040, en=4'hF: digits 3 and 2 are dark, digits 1 and 0 are lit (showing 4 and 0); with the macro unset, all four are lit.

Source files
------------

// File: rtl/sseg4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sseg4_pkg
// Brief    : Shared types and constants for the four-digit seven-segment scanner.
// Revision : 1.0 - initial release
// ============================================================================
package sseg4_pkg;

  localparam int SSEG_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  dp;
    logic [3:0]  en;
  } frame_t;

  // A digit survives blanking if its nibble or any higher nibble is non-zero.
  function automatic logic [3:0] lzb_keep(input logic [15:0] hex);
    logic [3:0] keep;
    keep[3] = (hex[15:12] != 4'h0);
    keep[2] = keep[3] | (hex[11:8] != 4'h0);
    keep[1] = keep[2] | (hex[7:4] != 4'h0);
    keep[0] = 1'b1;
    return keep;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sseg4_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : sseg4_tick_gen
// Brief    : Dwell prescaler; counts 0..DWELL_CYCLES-1 and flags the wrap cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sseg4_tick_gen #(
  parameter int DWELL_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_dwell_tick
);

  localparam int c_cnt_w = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DWELL_CYCLES - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_dwell_tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/sseg4_scan.sv
`default_nettype none
// ============================================================================
// Module   : sseg4_scan
// Brief    : Four-digit multiplexed display scanner with a one-deep frame buffer.
//            Define SSEG4_SCAN_LZB_EN to enable leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module sseg4_scan
  import sseg4_pkg::*;
#(
  parameter int DWELL_CYCLES = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [15:0] i_hex,
  input  logic [3:0]  i_dp,
  input  logic [3:0]  i_en,
  output logic [3:0]  o_hex,
  output logic        o_dp,
  output logic [3:0]  o_an_n,
  output logic        o_frame_tick
);

  localparam digit_idx_t c_last_idx = digit_idx_t'(SSEG_DIGITS - 1);

  logic       w_dwell_tick;
  logic       w_wrap;
  logic       w_accept;
  logic [3:0] w_lit_mask;
  logic [3:0] w_base;

  digit_idx_t r_idx;
  frame_t     r_active;
  frame_t     r_pend;
  logic       r_pend_full;

  sseg4_tick_gen #(
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_tick_gen (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .o_dwell_tick (w_dwell_tick)
  );

  assign w_wrap   = w_dwell_tick && (r_idx == c_last_idx);
  assign o_ready  = ~r_pend_full;
  assign w_accept = i_valid & ~r_pend_full;

  // Promotion only happens on the frame boundary so the active frame is
  // stable for a whole scan; a capture in that same cycle waits one frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx       <= '0;
      r_active    <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
    end else begin
      if (w_dwell_tick) begin
        r_idx <= r_idx + 2'd1;
      end
      if (w_wrap && r_pend_full) begin
        r_active    <= r_pend;
        r_pend_full <= 1'b0;
      end else if (w_accept) begin
        r_pend      <= '{hex: i_hex, dp: i_dp, en: i_en};
        r_pend_full <= 1'b1;
      end
    end
  end

`ifdef SSEG4_SCAN_LZB_EN
  assign w_lit_mask = r_active.en & lzb_keep(r_active.hex);
`else
  assign w_lit_mask = r_active.en;
`endif

  assign w_base       = {r_idx, 2'b00};
  assign o_hex        = r_active.hex[w_base +: 4];
  assign o_dp         = r_active.dp[r_idx];
  assign o_an_n       = w_lit_mask[r_idx] ? ~(4'b0001 << r_idx) : 4'b1111;
  assign o_frame_tick = w_wrap;

endmodule
`default_nettype wire

// File: tb/tb_sseg4_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg4_scan
// Brief    : Self-checking bench for sseg4_scan against a cycle-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sseg4_scan;

  localparam int DW    = 4;
  localparam int FRAME = 4 * DW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] hex = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  en = '0;
  logic        ready;
  logic [3:0]  o_hex;
  logic        o_dp;
  logic [3:0]  an_n;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: cyc counts rising edges since reset release.
  int          cyc = 0;
  logic        m_full = 1'b0;
  logic [15:0] a_hex = '0, p_hex = '0;
  logic [3:0]  a_dp = '0, p_dp = '0;
  logic [3:0]  a_en = '0, p_en = '0;

  sseg4_scan #(.DWELL_CYCLES(DW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .o_ready      (ready),
    .i_hex        (hex),
    .i_dp         (dp),
    .i_en         (en),
    .o_hex        (o_hex),
    .o_dp         (o_dp),
    .o_an_n       (an_n),
    .o_frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [3:0] lit_mask(input logic [15:0] h, input logic [3:0] e);
    logic [3:0] m = e;
`ifdef SSEG4_SCAN_LZB_EN
    for (int k = 1; k < 4; k++) begin
      if ((h >> (4 * k)) == 16'h0) m[k] = 1'b0;
    end
`endif
    return m;
  endfunction

  task automatic check_outputs();
    int          idx  = (cyc / DW) % 4;
    logic [3:0]  mask = lit_mask(a_hex, a_en);
    logic [15:0] sh   = a_hex >> (4 * idx);
    logic [3:0]  exp_an;
    exp_an = mask[idx] ? ~(4'b0001 << idx) : 4'b1111;
    check("an_n", 16'(an_n), 16'(exp_an));
    check("hex", 16'(o_hex), 16'(sh[3:0]));
    check("dp", 16'(o_dp), 16'(a_dp[idx]));
    check("frame_tick", 16'(frame_tick), 16'((cyc % FRAME) == FRAME - 1));
    check("ready", 16'(ready), 16'(!m_full));
  endtask

  // Called with clk low; drives inputs, checks, advances model across one edge.
  task automatic step(input logic v, input logic [15:0] h, input logic [3:0] d, input logic [3:0] e);
    logic accept, wrap;
    valid = v; hex = h; dp = d; en = e;
    #1;
    check_outputs();
    accept = v && !m_full;
    wrap   = (cyc % FRAME) == FRAME - 1;
    if (wrap && m_full) begin
      a_hex = p_hex; a_dp = p_dp; a_en = p_en; m_full = 1'b0;
    end else if (accept) begin
      p_hex = h; p_dp = d; p_en = e; m_full = 1'b1;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic do_reset();
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_an_n", 16'(an_n), 16'hF);
    check("rst_hex", 16'(o_hex), 16'h0);
    check("rst_dp", 16'(o_dp), 16'h0);
    check("rst_tick", 16'(frame_tick), 16'h0);
    check("rst_ready", 16'(ready), 16'h1);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_an_n", 16'(an_n), 16'hF);
    rst    = 1'b0;
    cyc    = 0;
    m_full = 1'b0;
    a_hex = '0; a_dp = '0; a_en = '0;
    p_hex = '0; p_dp = '0; p_en = '0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    idle(20);

    step(1'b1, 16'h1234, 4'b0101, 4'hF);
    idle(40);

    // Back-to-back offers: only the first lands until the slot drains.
    step(1'b1, 16'hAAAA, 4'b1111, 4'hF);
    for (int i = 0; i < 40; i++) step(1'b1, 16'hBBBB, 4'b0000, 4'hF);
    idle(40);

    // Offer landing exactly in the wrap cycle.
    while ((cyc % FRAME) != FRAME - 1) idle(1);
    step(1'b1, 16'h5678, 4'b1000, 4'hF);
    idle(40);

    step(1'b1, 16'h9ABC, 4'b0011, 4'b1010);
    idle(40);

    step(1'b1, 16'h0040, 4'b0000, 4'hF);
    idle(40);

    for (int i = 0; i < 300; i++) begin
      logic [15:0] nm;
      nm = {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}},
            {4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}}};
      step(($urandom % 8) == 0, 16'($urandom) & nm, 4'($urandom), 4'($urandom));
    end

    // Reset mid-frame with a pending frame outstanding.
    idle(5);
    step(1'b1, 16'hFEDC, 4'b1111, 4'hF);
    idle(3);
    do_reset();
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
